// File: rtl/processor_dout.sv
// processor_dout: Avalon-MM input port with a two-stage synchronizer, sticky per-bit edge capture
// and a masked level interrupt back to the soft processor.
module processor_dout #(
    parameter int DATA_WIDTH = 32,
    parameter int EDGE_TYPE  = 0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  read_n,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic                  irq
);
    logic [DATA_WIDTH-1:0] r_sync1, r_sync2, r_prev, r_edge_capture, r_irq_mask;
    logic [1:0]            r_arm;
    logic [DATA_WIDTH-1:0] w_edge, w_clear;
    logic [31:0]           w_rdmux;
    logic                  w_wr, w_armed, w_unused;

    assign w_unused = read_n ^ (^writedata);
    assign w_wr     = chipselect & ~write_n;
    assign w_armed  = (r_arm == 2'd3);
    assign w_edge   = (EDGE_TYPE == 0) ? (r_sync2 & ~r_prev) :
                      (EDGE_TYPE == 1) ? (~r_sync2 & r_prev) : (r_sync2 ^ r_prev);
    assign w_clear  = (w_wr && address == 2'd3) ? writedata[DATA_WIDTH-1:0] : '0;
    assign w_rdmux  = (address == 2'd0) ? 32'(r_sync2) :
                      (address == 2'd1) ? 32'(r_irq_mask) :
                      (address == 2'd3) ? 32'(r_edge_capture) : 32'd0;
    assign irq      = |(r_edge_capture & r_irq_mask);

    // set is OR-ed in after the clear so a coincident edge is never lost
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1        <= '0;
            r_sync2        <= '0;
            r_prev         <= '0;
            r_edge_capture <= '0;
            r_irq_mask     <= '0;
            r_arm          <= '0;
            readdata       <= '0;
        end else begin
            r_sync1        <= in_port;
            r_sync2        <= r_sync1;
            r_prev         <= r_sync2;
            r_arm          <= w_armed ? r_arm : r_arm + 2'd1;
            r_edge_capture <= (r_edge_capture & ~w_clear) | (w_armed ? w_edge : '0);
            if (w_wr && address == 2'd1)
                r_irq_mask <= writedata[DATA_WIDTH-1:0];
            readdata       <= w_rdmux;
        end
    end
endmodule

// File: tb/tb_processor_dout.sv
// tb_processor_dout: directed bench covering rising, falling and any-edge instances sharing one Avalon bus.
module tb_processor_dout;
    logic        clk = 0, reset_n = 0;
    logic [1:0]  address = 0;
    logic        chipselect = 0, read_n = 1, write_n = 1;
    logic [31:0] writedata = 0;
    logic [31:0] in0 = 32'hFFFF_FFFF, in1 = 0;
    logic [7:0]  in2 = 0;
    logic [31:0] rd0, rd1, rd2;
    logic        irq0, irq1, irq2;
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    processor_dout #(.DATA_WIDTH(32), .EDGE_TYPE(0)) u0 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd0), .in_port(in0), .irq(irq0));
    processor_dout #(.DATA_WIDTH(32), .EDGE_TYPE(1)) u1 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd1), .in_port(in1), .irq(irq1));
    processor_dout #(.DATA_WIDTH(8), .EDGE_TYPE(2)) u2 (.clk(clk), .reset_n(reset_n), .address(address),
        .chipselect(chipselect), .read_n(read_n), .write_n(write_n), .writedata(writedata),
        .readdata(rd2), .in_port(in2), .irq(irq2));

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [1:0] a);
        @(negedge clk);
        address = a; chipselect = 1; read_n = 0;
        @(posedge clk);
        #1;
        chipselect = 0; read_n = 1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; chipselect = 1; write_n = 0; writedata = d;
        @(posedge clk);
        #1;
        chipselect = 0; write_n = 1;
    endtask

    task automatic test_reset;
        cyc(2);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h exp %h", rd0, 32'h0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL rst_irq: got %b exp 0", irq0); end
        @(negedge clk) reset_n = 1;
        cyc(6);
        rd(3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL arm_edgecap0: got %h exp %h", rd0, 32'h0); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL arm_irq0: got %b exp 0", irq0); end
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL arm_edgecap1: got %h exp %h", rd1, 32'h0); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL arm_edgecap2: got %h exp %h", rd2, 32'h0); end
        rd(0);
        checks++; if (rd0 !== 32'hFFFF_FFFF) begin errors++; $display("FAIL data_read: got %h exp %h", rd0, 32'hFFFF_FFFF); end
    endtask

    task automatic test_irq;
        @(negedge clk) in0 = 32'h0;
        cyc(4);
        wr(1, 32'h1);
        @(negedge clk) in0 = 32'h1;
        @(posedge clk); #1;
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_e0: got %b exp 0", irq0); end
        @(posedge clk); #1;
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_e1: got %b exp 0", irq0); end
        @(posedge clk); #1;
        checks++; if (irq0 !== 1'b1) begin errors++; $display("FAIL irq_e2: got %b exp 1", irq0); end
        rd(3);
        checks++; if (rd0 !== 32'h1) begin errors++; $display("FAIL irq_edgecap: got %h exp %h", rd0, 32'h1); end
        wr(3, 32'h1);
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL irq_clear: got %b exp 0", irq0); end
        rd(3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL irq_edgecap_clr: got %h exp %h", rd0, 32'h0); end
    endtask

    task automatic test_falling;
        @(negedge clk) in1 = 32'hF0;
        cyc(4);
        @(negedge clk) in1 = 32'h30;
        cyc(4);
        rd(3);
        checks++; if (rd1 !== 32'hC0) begin errors++; $display("FAIL fall_edgecap: got %h exp %h", rd1, 32'hC0); end
        checks++; if (irq1 !== 1'b0) begin errors++; $display("FAIL fall_irq_masked: got %b exp 0", irq1); end
        wr(3, 32'h40);
        rd(3);
        checks++; if (rd1 !== 32'h80) begin errors++; $display("FAIL fall_w1c: got %h exp %h", rd1, 32'h80); end
        wr(3, 32'hFFFF_FFFF);
        rd(3);
        checks++; if (rd1 !== 32'h0) begin errors++; $display("FAIL fall_clear_all: got %h exp %h", rd1, 32'h0); end
    endtask

    task automatic test_simultaneous;
        @(negedge clk) in0 = 32'h9;
        @(posedge clk);
        @(posedge clk);
        wr(3, 32'h8);
        rd(3);
        checks++; if (rd0 !== 32'h8) begin errors++; $display("FAIL simul_set_wins: got %h exp %h", rd0, 32'h8); end
        checks++; if (irq0 !== 1'b0) begin errors++; $display("FAIL simul_irq_unmasked: got %b exp 0", irq0); end
        wr(3, 32'h8);
        rd(3);
        checks++; if (rd0 !== 32'h0) begin errors++; $display("FAIL simul_later_clear: got %h exp %h", rd0, 32'h0); end
    endtask

    task automatic test_any_edge;
        wr(1, 32'h80);
        @(negedge clk) in2 = 8'h80;
        cyc(4);
        @(negedge clk) in2 = 8'h00;
        cyc(4);
        rd(3);
        checks++; if (rd2 !== 32'h80) begin errors++; $display("FAIL any_edgecap: got %h exp %h", rd2, 32'h80); end
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL any_irq: got %b exp 1", irq2); end
        rd(1);
        checks++; if (rd2 !== 32'h80) begin errors++; $display("FAIL any_mask_read: got %h exp %h", rd2, 32'h80); end
        wr(1, 32'hFFFF_FFFF);
        rd(1);
        checks++; if (rd2 !== 32'hFF) begin errors++; $display("FAIL any_mask_width: got %h exp %h", rd2, 32'hFF); end
        wr(1, 32'h80);
        rd(2);
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL reserved_read: got %h exp %h", rd2, 32'h0); end
    endtask

    task automatic test_reset_mid;
        rd(1);
        checks++; if (rd2 !== 32'h80) begin errors++; $display("FAIL pre_rst_mask: got %h exp %h", rd2, 32'h80); end
        checks++; if (irq2 !== 1'b1) begin errors++; $display("FAIL pre_rst_irq: got %b exp 1", irq2); end
        @(posedge clk);
        #2 reset_n = 0;
        #1;
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL mid_rst_irq: got %b exp 0", irq2); end
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL mid_rst_readdata: got %h exp %h", rd2, 32'h0); end
        @(negedge clk) reset_n = 1;
        rd(3);
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL mid_rst_edgecap: got %h exp %h", rd2, 32'h0); end
        rd(1);
        checks++; if (rd2 !== 32'h0) begin errors++; $display("FAIL mid_rst_mask: got %h exp %h", rd2, 32'h0); end
        checks++; if (irq2 !== 1'b0) begin errors++; $display("FAIL post_rst_irq: got %b exp 0", irq2); end
    endtask

    initial begin
        test_reset;
        test_irq;
        test_falling;
        test_simultaneous;
        test_any_edge;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/processor_dout.md
# processor_dout

Avalon-MM slave input port for the processor subsystem: the return path from the 3D-engine fabric to the soft processor, complementing the processor's output data port. It samples a fabric-driven `in_port` bus through a two-stage synchronizer and detects per-bit edges into a sticky edge-capture register. It raises a level interrupt for edges not masked off by the interrupt mask. The processor reads live data and captured edges over a 4-word register map.

## Interface
Parameters:
- `DATA_WIDTH`, 32: implemented bits of `in_port`, 1..32; unimplemented readdata bits read 0.
- `EDGE_TYPE`, 0: 0 = rising, 1 = falling, 2 = any edge.

Ports:
- `clk` in 1: single clock; all state on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `address` in 2: word address. 0 = DATA, 1 = IRQMASK, 2 = reserved, 3 = EDGECAP.
- `chipselect` in 1: slave select.
- `read_n` in 1: active-low read strobe.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `in_port` in DATA_WIDTH: asynchronous input bus from the fabric.
- `irq` out 1: level interrupt, active high.

## Operation
- Reset: `sync1`, `sync2`, `prev`, `edge_capture`, `irq_mask`, `readdata`, `arm` are cleared to 0, so `irq` = 0.
- Sampling pipeline, every cycle: `sync1` ← `in_port`; `sync2` ← `sync1`; `prev` ← `sync2`.
- Per-bit edge detect:
  - rise = `sync2 & ~prev`
  - fall = `~sync2 & prev`
  - any = `sync2 ^ prev`
  - Selected by EDGE_TYPE.
- Arm counter: 2-bit, increments each cycle after reset release and saturates at 3. `edge_capture` may set only while `arm` == 3. This suppresses spurious edges from the reset-cleared pipeline.
- `edge_capture[i]` is sticky:
  - Set on a detected edge when armed.
  - Cleared only by a write to EDGECAP with `writedata[i]` = 1.
  - If a set and a clear hit the same bit in the same cycle, set wins; no edge is lost.
- Writes (`chipselect` & ~`write_n`):
  - addr 1 loads `irq_mask[DATA_WIDTH-1:0]`.
  - addr 3 performs write-one-to-clear on `edge_capture`.
  - addr 0 and addr 2 are ignored.
- Read mux, by address:
  - addr 0 returns `sync2`.
  - addr 1 returns `irq_mask`.
  - addr 2 returns 0.
  - addr 3 returns `edge_capture`.
  - Unused upper bits are zero-extended.
- `readdata` register is loaded from the mux every cycle regardless of `read_n`/`chipselect`. Reads have no side effects.
- `irq` = |(`edge_capture` & `irq_mask`). It is combinational from registers only, so it is glitch-free.

## Timing
- Read latency is 1 cycle. The address is presented at edge N; `readdata` is valid after edge N+1 and holds until the next edge.
- `in_port` stable before edge E0:
  - `sync2` updates at E1.
  - A DATA read presented at E1 returns the new value after E2.
  - The edge is captured at E2 (if armed), and `irq` rises after E2 if the bit is masked in.
- After reset release, the first rising clk edge is R1. The earliest `edge_capture` set is at R4.
- The EDGECAP clear takes effect at the write edge. `irq` deasserts the same cycle, unless another masked bit remains set.
- An IRQMASK write changes `irq` immediately after the write edge; captured edges are unaffected.
- `reset_n` asserted mid-operation clears all state asynchronously, including pending edges, and re-arms the counter from 0.
- Pulses shorter than one clk period may be missed. The input must hold at least 2 cycles to be guaranteed seen.

## Test plan
- Reset, DATA_WIDTH=32, EDGE_TYPE=0:
  - Hold `in_port`=0xFFFF_FFFF through reset release → EDGECAP reads 0x0 and `irq`=0 (arm suppression).
  - DATA read returns 0xFFFF_FFFF with 1-cycle latency.
- Write IRQMASK=0x0000_0001, then drive bit0 0→1 → `irq` high exactly 3 edges after the change; EDGECAP=0x1.
  - Write EDGECAP=0x1 → `irq` low after the write edge.
- EDGE_TYPE=1, in_port 0x0000_00F0 → 0x0000_0030 → EDGECAP=0x0000_00C0.
  - Write 0x40 → EDGECAP reads 0x80.
- Simultaneous: a W1C write of bit3 in the same cycle bit3's edge is detected → EDGECAP bit3 remains 1.
- EDGE_TYPE=2, DATA_WIDTH=8: toggle bit7 twice, mask 0x80 → one capture, `irq`=1.
  - Reads of IRQMASK return 0x0000_0080 with upper bits zero; reserved addr 2 reads 0.
  - Assert `reset_n` mid-test → `irq`, `readdata`, EDGECAP and IRQMASK are all 0 immediately.
